// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the ALU scheduler: FSM state encoding,
// ALU input-select codes and one-hot op bit positions.
package alu_sched_pkg;

  typedef enum logic [2:0] {
    OFF   = 3'd0,
    IDLE  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4,
    ERR   = 3'd5
  } stateT;

  localparam logic [2:0] ALU_PERSIST = 3'b100;
  localparam logic [2:0] ALU_LOAD    = 3'b010;
  localparam logic [2:0] ALU_CLEAR   = 3'b001;

  localparam int OP_AND  = 0;
  localparam int OP_OR   = 1;
  localparam int OP_NOT  = 2;
  localparam int OP_XOR  = 3;
  localparam int OP_ADD  = 4;
  localparam int OP_SUB  = 5;
  localparam int OP_MULT = 6;

  function automatic logic isOneHot(input logic [6:0] op);
    return (op != 7'd0) && ((op & (op - 7'd1)) == 7'd0);
  endfunction

endpackage

// File: rtl/alu_scheduler_rr_arb2.sv
// Two-way round-robin arbiter; the last-grant pointer moves only on an
// accepted request so an unserved requester keeps its turn.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant,
  output logic       grantId,
  output logic       handshake
);

  logic lastGrant;

  always_comb begin
    grant   = 2'b00;
    grantId = 1'b0;
    if (req[0] && req[1]) grantId = ~lastGrant;
    else                  grantId = req[1];
    if (en && (req != 2'b00)) grant = grantId ? 2'b10 : 2'b01;
  end

  assign handshake = |(grant & req);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            lastGrant <= 1'b1;
    else if (handshake) lastGrant <= grantId;
  end

endmodule

// File: rtl/alu_scheduler.sv
// Two-requester scheduler for an external multi-cycle ALU.
// Optional overflow trap: define ALU_SCHED_OVF_TRAP_EN.
//
// state | meaning
// OFF   | disabled, waiting for on
// IDLE  | arbitrating requesters
// ISSUE | first cycle of operand load into the ALU
// WAIT  | ALU_LAT cycles, down-counter to terminal count 0
// RESP  | response valid, waiting for rsp_ready
// ERR   | one-cycle overflow trap
module alu_scheduler
  import alu_sched_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             on,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [6:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [6:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_ovf,
  output logic             rsp_ill,
  output logic [2:0]       alu_in_sel,
  output logic [WIDTH-1:0] alu_num1,
  output logic [WIDTH-1:0] alu_num2,
  output logic [6:0]       alu_out_sel,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_ovf,
  output logic [2:0]       state,
  output logic [7:0]       err_cnt
);

  stateT            stateQ, stateNext;
  logic [2:0]       cnt;
  logic [WIDTH-1:0] aQ, bQ;
  logic [6:0]       opQ;
  logic [1:0]       grant;
  logic             grantId, hs;
  logic [WIDTH-1:0] selA, selB;
  logic [6:0]       selOp;

  rr_arb2 uArb (
    .clk       (clk),
    .rst       (rst),
    .req       ({req1_valid, req0_valid}),
    .en        (stateQ == IDLE && on),
    .grant     (grant),
    .grantId   (grantId),
    .handshake (hs)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign selA       = grantId ? req1_a  : req0_a;
  assign selB       = grantId ? req1_b  : req0_b;
  assign selOp      = grantId ? req1_op : req0_op;
  assign rsp_valid  = (stateQ == RESP);
  assign state      = stateQ;

`ifdef ALU_SCHED_OVF_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
  logic [7:0] errCnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) errCnt <= 8'd0;
    else if (stateQ == RESP && rsp_ready && rsp_ovf && errCnt != 8'hFF)
      errCnt <= errCnt + 8'd1;
  end
  assign err_cnt = errCnt;
`else
  localparam bit TRAP_EN = 1'b0;
  assign err_cnt = 8'd0;
`endif

  always_comb begin
    stateNext   = stateQ;
    alu_in_sel  = ALU_CLEAR;
    alu_num1    = '0;
    alu_num2    = '0;
    alu_out_sel = 7'd0;
    case (stateQ)
      OFF:  if (on) stateNext = IDLE;
      IDLE: begin
        if (!on)    stateNext = OFF;
        else if (hs) stateNext = isOneHot(selOp) ? ISSUE : RESP;
      end
      ISSUE, WAIT: begin
        alu_in_sel  = ALU_LOAD;
        alu_num1    = aQ;
        alu_num2    = bQ;
        alu_out_sel = opQ;
        if (stateQ == ISSUE)  stateNext = WAIT;
        else if (cnt == 3'd0) stateNext = RESP;
      end
      RESP: begin
        // Illegal ops never reach the ALU, so hold it without operands.
        alu_in_sel = ALU_PERSIST;
        if (!rsp_ill) begin
          alu_num1    = aQ;
          alu_num2    = bQ;
          alu_out_sel = opQ;
        end
        if (rsp_ready) begin
          if (TRAP_EN && rsp_ovf) stateNext = ERR;
          else                    stateNext = on ? IDLE : OFF;
        end
      end
      ERR:     stateNext = on ? IDLE : OFF;
      default: stateNext = OFF;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ   <= OFF;
      cnt      <= 3'd0;
      aQ       <= '0;
      bQ       <= '0;
      opQ      <= 7'd0;
      rsp_id   <= 1'b0;
      rsp_data <= '0;
      rsp_ovf  <= 1'b0;
      rsp_ill  <= 1'b0;
    end else begin
      stateQ <= stateNext;
      if (stateQ == IDLE && hs) begin
        aQ     <= selA;
        bQ     <= selB;
        opQ    <= selOp;
        rsp_id <= grantId;
        if (!isOneHot(selOp)) begin
          rsp_data <= '0;
          rsp_ovf  <= 1'b0;
          rsp_ill  <= 1'b1;
        end else begin
          rsp_ill  <= 1'b0;
        end
      end
      if (stateQ == ISSUE)                 cnt <= 3'(ALU_LAT - 1);
      else if (stateQ == WAIT && cnt != 0) cnt <= cnt - 3'd1;
      if (stateQ == WAIT && cnt == 3'd0) begin
        rsp_data <= alu_result;
        rsp_ovf  <= alu_ovf;
      end
    end
  end

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed bench for alu_scheduler with a behavioural ALU and hand-computed
// expectations; overflow-trap expectations follow ALU_SCHED_OVF_TRAP_EN.
module tb_alu_scheduler;
  import alu_sched_pkg::*;

  localparam int WIDTH   = 8;
  localparam int ALU_LAT = 1;

  logic clk = 1'b0, rst = 1'b0, on = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0, req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [6:0] req0_op = '0, req1_op = '0;
  logic rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_ovf, rsp_ill;
  logic [WIDTH-1:0] rsp_data, alu_num1, alu_num2, alu_result;
  logic [2:0] alu_in_sel, state;
  logic [6:0] alu_out_sel;
  logic alu_ovf, ovfForce = 1'b0;
  logic [7:0] err_cnt;

  int checks = 0, errors = 0;

  alu_scheduler #(.WIDTH(WIDTH), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .rst(rst), .on(on),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_ovf(rsp_ovf), .rsp_ill(rsp_ill),
    .alu_in_sel(alu_in_sel), .alu_num1(alu_num1), .alu_num2(alu_num2), .alu_out_sel(alu_out_sel),
    .alu_result(alu_result), .alu_ovf(alu_ovf), .state(state), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_result = '0;
    if (alu_out_sel[OP_ADD])       alu_result = alu_num1 + alu_num2;
    else if (alu_out_sel[OP_SUB])  alu_result = alu_num1 - alu_num2;
    else if (alu_out_sel[OP_MULT]) alu_result = alu_num1 * alu_num2;
    else if (alu_out_sel[OP_XOR])  alu_result = alu_num1 ^ alu_num2;
    else if (alu_out_sel[OP_AND])  alu_result = alu_num1 & alu_num2;
    else if (alu_out_sel[OP_OR])   alu_result = alu_num1 | alu_num2;
    else if (alu_out_sel[OP_NOT])  alu_result = ~alu_num1;
  end
  assign alu_ovf = ovfForce;

  task automatic tick();
    @(negedge clk);
  endtask

  // which: 0 = req0, 1 = req1, 2 = either
  task automatic waitReady(input int which, output bit ok);
    #1;
    for (int i = 0; i < 30; i++) begin
      if ((which != 1 && req0_ready) || (which != 0 && req1_ready)) break;
      @(negedge clk); #1;
    end
    ok = (which != 1 && req0_ready) || (which != 0 && req1_ready);
  endtask

  task automatic waitRsp(output bit ok, output int n);
    n = 0;
    while (!rsp_valid && n < 30) begin
      @(negedge clk); #1; n++;
    end
    ok = rsp_valid;
  endtask

  task automatic doReset();
    tick(); rst = 1'b1; on = 1'b0;
    tick(); rst = 1'b0;
  endtask

  task automatic test_reset();
    doReset(); #1;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    checks++; if ({req0_ready, req1_ready, rsp_valid} !== 3'b000) begin errors++; $display("FAIL reset_handshakes: got %b want 000", {req0_ready, req1_ready, rsp_valid}); end
    checks++; if (rsp_data !== 8'h00) begin errors++; $display("FAIL reset_rsp_data: got %h want 00", rsp_data); end
    checks++; if (alu_in_sel !== 3'b001) begin errors++; $display("FAIL reset_alu_in_sel: got %b want 001", alu_in_sel); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
  endtask

  task automatic test_basic();
    bit ok; int n;
    on = 1'b1; tick();
    req0_valid = 1'b1; req0_a = 8'h05; req0_b = 8'h03; req0_op = 7'b0010000;
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("FAIL basic_ready: got %b want 01", {req1_ready, req0_ready}); end
    tick(); req0_valid = 1'b0; #1;
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL basic_issue_state: got %0d want 2", state); end
    checks++; if ({alu_in_sel, alu_num1, alu_num2, alu_out_sel} !== {3'b010, 8'h05, 8'h03, 7'b0010000})
      begin errors++; $display("FAIL basic_alu_drive: got sel=%b n1=%h n2=%h op=%b want 010 05 03 0010000", alu_in_sel, alu_num1, alu_num2, alu_out_sel); end
    waitRsp(ok, n);
    // handshake edge counted as 1, then ISSUE and ALU_LAT WAIT cycles
    checks++; if (!ok || (n + 1) != ALU_LAT + 2) begin errors++; $display("FAIL basic_latency: got %0d want %0d", n + 1, ALU_LAT + 2); end
    checks++; if ({rsp_data, rsp_id, rsp_ill, rsp_ovf} !== {8'h08, 3'b000}) begin errors++; $display("FAIL basic_payload: got data=%h id=%b ill=%b ovf=%b want 08 0 0 0", rsp_data, rsp_id, rsp_ill, rsp_ovf); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0; #1;
    checks++; if (state !== 3'd1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL basic_return_idle: got state=%0d valid=%b want 1 0", state, rsp_valid); end
  endtask

  task automatic test_round_robin();
    bit ok; int n; logic gid;
    doReset(); on = 1'b1; tick();
    req0_valid = 1'b1; req0_a = 8'h10; req0_b = 8'h01; req0_op = 7'b0010000;
    req1_valid = 1'b1; req1_a = 8'h20; req1_b = 8'h01; req1_op = 7'b0010000;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      waitReady(2, ok);
      gid = req1_ready;
      checks++; if (!ok || (req0_ready && req1_ready) || gid !== k[0])
        begin errors++; $display("FAIL rr_grant_%0d: got r0=%b r1=%b want grant %0d", k, req0_ready, req1_ready, k[0]); end
      tick();
      waitRsp(ok, n);
      checks++; if (!ok || rsp_id !== k[0] || rsp_data !== (k[0] ? 8'h21 : 8'h11))
        begin errors++; $display("FAIL rr_rsp_%0d: got id=%b data=%h want %0d %h", k, rsp_id, rsp_data, k[0], k[0] ? 8'h21 : 8'h11); end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok; int n;
    req1_valid = 1'b1; req1_a = 8'hF0; req1_b = 8'h3C; req1_op = 7'b0001000;
    waitReady(1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_ready1: got 0 want 1"); end
    tick(); req1_valid = 1'b0; req0_valid = 1'b1; req0_op = 7'b0010000;
    waitRsp(ok, n);
    for (int i = 0; i < 5; i++) begin
      checks++; if ({rsp_valid, rsp_data, rsp_id, req0_ready, req1_ready} !== {1'b1, 8'hCC, 3'b100})
        begin errors++; $display("FAIL bp_hold_%0d: got v=%b data=%h id=%b r0=%b r1=%b want 1 cc 1 0 0", i, rsp_valid, rsp_data, rsp_id, req0_ready, req1_ready); end
      tick(); #1;
    end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0; #1;
    checks++; if (rsp_valid !== 1'b0 || req0_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got v=%b r0=%b want 0 1", rsp_valid, req0_ready); end
    req0_valid = 1'b0;
  endtask

  task automatic test_illegal();
    bit ok;
    req1_valid = 1'b1; req1_a = 8'h55; req1_b = 8'h66; req1_op = 7'b0000011;
    waitReady(1, ok);
    tick(); req1_valid = 1'b0; #1;
    checks++; if (!ok || {state, rsp_valid, rsp_ill, rsp_data, rsp_id} !== {3'd4, 2'b11, 8'h00, 1'b1})
      begin errors++; $display("FAIL ill_rsp: got st=%0d v=%b ill=%b data=%h id=%b want 4 1 1 00 1", state, rsp_valid, rsp_ill, rsp_data, rsp_id); end
    checks++; if (alu_in_sel === 3'b010) begin errors++; $display("FAIL ill_no_load: got %b want not 010", alu_in_sel); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0; #1;
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL ill_idle: got %0d want 1", state); end
  endtask

  task automatic test_overflow();
    bit ok; int n;
    ovfForce = 1'b1;
    req0_valid = 1'b1; req0_a = 8'h20; req0_b = 8'h10; req0_op = 7'b1000000;
    waitReady(0, ok);
    tick(); req0_valid = 1'b0;
    waitRsp(ok, n);
    checks++; if (!ok || {rsp_ovf, rsp_ill, rsp_data} !== {2'b10, 8'h00})
      begin errors++; $display("FAIL ovf_rsp: got ovf=%b ill=%b data=%h want 1 0 00", rsp_ovf, rsp_ill, rsp_data); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0; req0_valid = 1'b1; #1;
`ifdef ALU_SCHED_OVF_TRAP_EN
    checks++; if ({state, req0_ready, err_cnt} !== {3'd5, 1'b0, 8'd1})
      begin errors++; $display("FAIL ovf_trap: got st=%0d r0=%b err=%0d want 5 0 1", state, req0_ready, err_cnt); end
    tick(); #1;
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL ovf_after_err: got %0d want 1", state); end
`else
    checks++; if ({state, err_cnt} !== {3'd1, 8'd0})
      begin errors++; $display("FAIL ovf_no_trap: got st=%0d err=%0d want 1 0", state, err_cnt); end
`endif
    req0_valid = 1'b0; ovfForce = 1'b0;
  endtask

  task automatic test_power();
    bit ok; int n;
    req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h02; req0_op = 7'b0010000;
    waitReady(0, ok);
    tick(); req0_valid = 1'b0; on = 1'b0;
    waitRsp(ok, n);
    checks++; if (!ok || rsp_data !== 8'h03) begin errors++; $display("FAIL pwr_finish: got v=%b data=%h want 1 03", rsp_valid, rsp_data); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0; req0_valid = 1'b1; #1;
    checks++; if (state !== 3'd0 || req0_ready !== 1'b0) begin errors++; $display("FAIL pwr_off: got st=%0d r0=%b want 0 0", state, req0_ready); end
    req0_valid = 1'b0; on = 1'b1; tick(); on = 1'b0; #1;
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL pwr_on_idle: got %0d want 1", state); end
    tick(); #1;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL pwr_idle_off: got %0d want 0", state); end
    on = 1'b1; tick();
  endtask

  task automatic test_reset_mid();
    bit ok; int seen;
    req0_valid = 1'b1; req0_a = 8'h07; req0_b = 8'h01; req0_op = 7'b0100000;
    waitReady(0, ok);
    tick(); req0_valid = 1'b0;
    tick(); #1;
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL rstmid_wait: got %0d want 3", state); end
    rst = 1'b1; #1;
    checks++; if ({state, rsp_valid, alu_in_sel, rsp_data, req0_ready} !== {3'd0, 1'b0, 3'b001, 8'h00, 1'b0})
      begin errors++; $display("FAIL rstmid_async: got st=%0d v=%b sel=%b data=%h r0=%b want 0 0 001 00 0", state, rsp_valid, alu_in_sel, rsp_data, req0_ready); end
    tick(); rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick(); #1;
      if (rsp_valid) seen++;
    end
    checks++; if (seen != 0 || state !== 3'd1) begin errors++; $display("FAIL rstmid_no_rsp: got rsp_cycles=%0d st=%0d want 0 1", seen, state); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_backpressure();
    test_illegal();
    test_overflow();
    test_power();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
